// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : wb_stage
// Brief   : RV32 writeback stage; selects write data, aligns loads, counts
//           retired instructions.
// Revision: 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_pc,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_data,
  output logic             wb_en,
  output logic [4:0]       wb_reg,
  output logic [31:0]      wb_val,
  output logic             load_err,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retire_count
);

  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_REG   = 7'b0110011;
  localparam logic [6:0] c_OP_IMM   = 7'b0010011;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam int         c_TW       = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  logic [c_TW-1:0]  r_timer;
  logic [4:0]       r_ld_rd;
  logic [2:0]       r_ld_f3;
  logic [1:0]       r_ld_addr;
  logic             r_wb_en;
  logic [4:0]       r_wb_reg;
  logic [31:0]      r_wb_val;
  logic             r_load_err;
  logic             r_misalign_err;
  logic [CNT_W-1:0] r_retire_count;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic        w_fire;
  logic        w_is_load;
  logic        w_writes;
  logic [31:0] w_sel_val;
  logic        w_misalign;
  logic        w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_val;
  logic        w_unused;

  assign w_opcode  = in_ins[6:0];
  assign w_rd      = in_ins[11:7];
  assign w_f3      = in_ins[14:12];
  assign w_unused  = ^in_ins[31:15];
  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign w_fire    = in_valid && in_ready;
  assign w_is_load = (w_opcode == c_OP_LOAD);
  assign w_timeout = (r_timer == c_TW'(LOAD_TIMEOUT - 1));

  always_comb begin
    w_writes  = 1'b0;
    w_sel_val = in_alu_result;
    case (w_opcode)
      c_OP_REG, c_OP_IMM, c_OP_LUI, c_OP_AUIPC: w_writes = 1'b1;
      c_OP_JAL, c_OP_JALR: begin
        w_writes  = 1'b1;
        w_sel_val = in_pc + 32'd4;
      end
      default: w_writes = 1'b0;
    endcase
  end

  // Unlisted funct3 encodings behave as LW for both alignment and extraction.
  always_comb begin
    w_misalign = 1'b0;
    case (w_f3)
      3'b000, 3'b100: w_misalign = 1'b0;
      3'b001, 3'b101: w_misalign = in_alu_result[0];
      default:        w_misalign = |in_alu_result[1:0];
    endcase
  end

  always_comb begin
    w_byte = mem_rsp_data[7:0];
    case (r_ld_addr)
      2'd0: w_byte = mem_rsp_data[7:0];
      2'd1: w_byte = mem_rsp_data[15:8];
      2'd2: w_byte = mem_rsp_data[23:16];
      2'd3: w_byte = mem_rsp_data[31:24];
      default: w_byte = mem_rsp_data[7:0];
    endcase
    w_half = r_ld_addr[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    case (r_ld_f3)
      3'b000:  w_ld_val = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ld_val = {24'd0, w_byte};
      3'b001:  w_ld_val = {{16{w_half[15]}}, w_half};
      3'b101:  w_ld_val = {16'd0, w_half};
      default: w_ld_val = mem_rsp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_fire && w_is_load && !w_misalign) w_state_nxt = S_WAIT;
      S_WAIT: if (mem_rsp_valid || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer        <= '0;
      r_ld_rd        <= '0;
      r_ld_f3        <= '0;
      r_ld_addr      <= '0;
      r_wb_en        <= 1'b0;
      r_wb_reg       <= '0;
      r_wb_val       <= '0;
      r_load_err     <= 1'b0;
      r_misalign_err <= 1'b0;
      r_retire_count <= '0;
    end else begin
      r_wb_en        <= 1'b0;
      r_load_err     <= 1'b0;
      r_misalign_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            if (w_is_load) begin
              r_ld_rd   <= w_rd;
              r_ld_f3   <= w_f3;
              r_ld_addr <= in_alu_result[1:0];
              r_timer   <= '0;
              if (w_misalign) begin
                r_misalign_err <= 1'b1;
                r_retire_count <= r_retire_count + CNT_W'(1);
              end
            end else begin
              r_retire_count <= r_retire_count + CNT_W'(1);
              if (w_writes && (w_rd != 5'd0)) begin
                r_wb_en  <= 1'b1;
                r_wb_reg <= w_rd;
                r_wb_val <= w_sel_val;
              end
            end
          end
        end
        S_WAIT: begin
          // A response on the timeout cycle still completes the load.
          if (mem_rsp_valid) begin
            r_retire_count <= r_retire_count + CNT_W'(1);
            if (r_ld_rd != 5'd0) begin
              r_wb_en  <= 1'b1;
              r_wb_reg <= r_ld_rd;
              r_wb_val <= w_ld_val;
            end
          end else if (w_timeout) begin
            r_load_err <= 1'b1;
          end else begin
            r_timer <= r_timer + c_TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_en        = r_wb_en;
  assign wb_reg       = r_wb_reg;
  assign wb_val       = r_wb_val;
  assign load_err     = r_load_err;
  assign misalign_err = r_misalign_err;
  assign retire_count = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_stage
// Brief   : Self-checking bench for wb_stage: reference model plus directed
//           vectors with literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  localparam int LOAD_TIMEOUT = 16;
  localparam int CNT_W        = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ins, in_alu_result, in_pc;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_val;
  logic        load_err, misalign_err;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;

  wb_stage #(.LOAD_TIMEOUT(LOAD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
    .in_alu_result(in_alu_result), .in_pc(in_pc),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_val(wb_val),
    .load_err(load_err), .misalign_err(misalign_err),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_armed = 0;
  bit          m_wait  = 0;
  int          m_waited = 0;
  logic [4:0]  m_ld_rd;
  logic [2:0]  m_ld_f3;
  logic [1:0]  m_ld_a;
  logic        m_en = 0, m_lerr = 0, m_merr = 0;
  logic [4:0]  m_reg = 0;
  logic [31:0] m_val = 0;
  logic [31:0] m_cnt = 0;

  function automatic logic [31:0] m_extract(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a)) % 256;
    h = (d >> (16 * (a / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == 3'd0 || f3 == 3'd4) return 0;
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) != 0;
    return a != 0;
  endfunction

  always @(posedge clk) begin
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] v;
    bit          wr;
    m_en = 0; m_lerr = 0; m_merr = 0;
    if (rst) begin
      m_armed = 1; m_wait = 0; m_waited = 0;
      m_reg = 0; m_val = 0; m_cnt = 0;
    end else if (m_wait) begin
      m_waited++;
      if (mem_rsp_valid) begin
        m_wait = 0;
        m_cnt  = m_cnt + 1;
        if (m_ld_rd != 0) begin
          m_en = 1; m_reg = m_ld_rd; m_val = m_extract(m_ld_f3, m_ld_a, mem_rsp_data);
        end
      end else if (m_waited == LOAD_TIMEOUT) begin
        m_wait = 0; m_lerr = 1;
      end
    end else if (in_valid) begin
      op = in_ins[6:0]; rd = in_ins[11:7]; f3 = in_ins[14:12];
      if (op == 7'h03) begin
        if (m_misaligned(f3, in_alu_result[1:0])) begin
          m_merr = 1; m_cnt = m_cnt + 1;
        end else begin
          m_wait = 1; m_waited = 0;
          m_ld_rd = rd; m_ld_f3 = f3; m_ld_a = in_alu_result[1:0];
        end
      end else begin
        m_cnt = m_cnt + 1;
        wr = 0; v = in_alu_result;
        if (op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h17) wr = 1;
        if (op == 7'h6F || op == 7'h67) begin wr = 1; v = in_pc + 4; end
        if (wr && rd != 0) begin m_en = 1; m_reg = rd; m_val = v; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      chk("in_ready",     {31'd0, in_ready},     {31'd0, !m_wait && !rst});
      chk("wb_en",        {31'd0, wb_en},        {31'd0, m_en});
      chk("wb_reg",       {27'd0, wb_reg},       {27'd0, m_reg});
      chk("wb_val",       wb_val,                m_val);
      chk("load_err",     {31'd0, load_err},     {31'd0, m_lerr});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_merr});
      chk("retire_count", retire_count,          m_cnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] a, input logic [31:0] p);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1; in_ins = i; in_alu_result = a; in_pc = p;
    tick();
    in_valid = 0;
  endtask

  task automatic respond(input int delay, input logic [31:0] d);
    repeat (delay) tick();
    chk("wait_not_ready", {31'd0, in_ready}, 32'd0);
    mem_rsp_valid = 1; mem_rsp_data = d;
    tick();
    mem_rsp_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1; in_valid = 0; in_ins = 0; in_alu_result = 0; in_pc = 0;
    mem_rsp_valid = 0; mem_rsp_data = 0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wb_val", wb_val, 32'd0);
    chk("rst_count", retire_count, 32'd0);
    rst = 0;
    tick();

    send(32'h00A00093, 32'h0000000A, 32'h0);
    chk("addi_en", {31'd0, wb_en}, 32'd1);
    chk("addi_reg", {27'd0, wb_reg}, 32'd1);
    chk("addi_val", wb_val, 32'h0000000A);
    chk("addi_cnt", retire_count, 32'd1);
    tick();
    chk("addi_pulse", {31'd0, wb_en}, 32'd0);

    send(32'h000002EF, 32'h0, 32'h00000100);
    chk("jal_reg", {27'd0, wb_reg}, 32'd5);
    chk("jal_val", wb_val, 32'h00000104);
    send(32'h00000013, 32'h0, 32'h0);
    chk("nop_en", {31'd0, wb_en}, 32'd0);
    chk("nop_hold", wb_val, 32'h00000104);
    chk("nop_cnt", retire_count, 32'd3);

    send(32'h00000183, 32'h00001003, 32'h0);
    respond(2, 32'h80FF1234);
    chk("lb_val", wb_val, 32'hFFFFFF80);
    send(32'h00004183, 32'h00001003, 32'h0);
    respond(2, 32'h80FF1234);
    chk("lbu_val", wb_val, 32'h00000080);

    send(32'h00001203, 32'h00002002, 32'h0);
    respond(1, 32'h8001ABCD);
    chk("lh_val", wb_val, 32'hFFFF8001);
    send(32'h00002303, 32'h00002001, 32'h0);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_ready", {31'd0, in_ready}, 32'd1);
    chk("mis_cnt", retire_count, 32'd7);

    send(32'h00002303, 32'h00003000, 32'h0);
    repeat (LOAD_TIMEOUT - 1) tick();
    chk("to_early", {31'd0, load_err}, 32'd0);
    tick();
    chk("to_err", {31'd0, load_err}, 32'd1);
    chk("to_cnt", retire_count, 32'd7);
    chk("to_ready", {31'd0, in_ready}, 32'd1);

    send(32'h00002303, 32'h00003004, 32'h0);
    respond(LOAD_TIMEOUT - 1, 32'hDEADBEEF);
    chk("race_val", wb_val, 32'hDEADBEEF);
    chk("race_noerr", {31'd0, load_err}, 32'd0);
    send(32'h00A00093, 32'h00000055, 32'h0);
    chk("b2b_val", wb_val, 32'h00000055);
    chk("b2b_cnt", retire_count, 32'd9);

    send(32'h00000023, 32'h0, 32'h0);
    send(32'h00002003, 32'h00000000, 32'h0);
    respond(1, 32'h12345678);
    chk("x0_load_en", {31'd0, wb_en}, 32'd0);
    chk("x0_load_cnt", retire_count, 32'd11);
    mem_rsp_valid = 1; mem_rsp_data = 32'hFFFFFFFF;
    tick();
    mem_rsp_valid = 0;

    send(32'h00002303, 32'h00004000, 32'h0);
    repeat (2) tick();
    rst = 1;
    tick();
    rst = 0;
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFEF00D;
    tick();
    mem_rsp_valid = 0;
    chk("abort_en", {31'd0, wb_en}, 32'd0);
    chk("abort_val", wb_val, 32'd0);
    chk("abort_cnt", retire_count, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage of the RV32 pipeline. It is the writer end of the register-file write/forward interface (wb_en, wb_reg, wb_val) that the register-read stage consumes. It accepts one retiring instruction per handshake and selects the value to write. Loads stall until memory responds, then the returned word is aligned and sign- or zero-extended. It drives a one-cycle write pulse and counts retired instructions.

Parameters:
LOAD_TIMEOUT, 16, max cycles in WAIT_LOAD before aborting the load (≥1)
CNT_W, 32, width of retire counter

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  retiring instruction present
in_ready  out  1  stage can accept (combinational from state)
in_ins  in  32  instruction word
in_alu_result  in  32  ALU result, or effective address for loads
in_pc  in  32  instruction PC
mem_rsp_valid  in  1  load data valid (one-cycle pulse)
mem_rsp_data  in  32  aligned 32-bit word containing load data
wb_en  out  1  register write strobe
wb_reg  out  5  destination register
wb_val  out  32  write data
load_err  out  1  load timed out (one-cycle pulse)
misalign_err  out  1  misaligned load (one-cycle pulse)
retire_count  out  CNT_W  instructions retired

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset forces state IDLE, wb_en=0, wb_reg=0, wb_val=0, load_err=0, misalign_err=0, retire_count=0, timer=0. in_ready=0 while rst=1.
- A transfer occurs when in_valid & in_ready at a posedge.
- States:
  - IDLE: in_ready=1.
  - WAIT_LOAD: in_ready=0.
- Decode fields: opcode=in_ins[6:0], rd=in_ins[11:7], funct3=in_ins[14:12].
- Write value by opcode:
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111: in_alu_result.
  - JAL 1101111, JALR 1100111: in_pc+4, mod 2^32.
  - STORE, BRANCH, MISC-MEM, SYSTEM, or any unknown opcode: no write.
- Non-load transfer: on the next cycle wb_en=1, wb_reg=rd, wb_val=the selected value. Latency is 1 cycle. retire_count increments by 1.
- rd==0 forces wb_en=0; the instruction still retires. NOP 0x00000013 retires with no write.
- No-write instructions: wb_en=0 the next cycle; retire_count still increments.
- wb_en lasts exactly 1 cycle per write. wb_reg and wb_val hold their last values when wb_en=0.
- Load transfer (opcode 0000011): latch rd, funct3 and addr[1:0]=in_alu_result[1:0].
  - Misalignment check: LH/LHU with addr[0]=1, or LW with addr[1:0]≠0.
  - If misaligned: next cycle misalign_err=1, wb_en=0, instruction retires, state stays IDLE.
  - Otherwise: go to WAIT_LOAD and clear the timer.
- WAIT_LOAD: the timer increments each cycle.
  - On mem_rsp_valid: next cycle wb_en=(rd≠0), wb_val=extracted data, retire_count+1, state IDLE.
  - If the timer reaches LOAD_TIMEOUT without a response: next cycle load_err=1, wb_en=0, no retire, state IDLE.
  - Response and timeout in the same cycle: the response wins.
- Extraction (selection by addr[1:0]):
  - LB 000: byte = data[8*addr+7 : 8*addr], sign-extended.
  - LBU 100: same byte, zero-extended.
  - LH 001: half = data[16*addr[1]+15 : 16*addr[1]], sign-extended.
  - LHU 101: same half, zero-extended.
  - LW 010: full word.
  - Other funct3 values: treated as LW.
- mem_rsp_valid in IDLE is ignored.
- The transfer that completes a load can be followed by a new transfer in the very next cycle (back-to-back, once in IDLE).
- rst during WAIT_LOAD aborts the load: no write, no error pulse. A response arriving after reset is ignored.
- retire_count wraps modulo 2^CNT_W.

Test Plan:
- Reset, then transfer ins=0x00A00093 (addi x1), alu=0x0000000A → 1 cycle later wb_en=1, wb_reg=1, wb_val=0x0000000A, retire_count=1; wb_en=0 on the following cycle.
- Transfer JAL x5 with pc=0x00000100 → wb_en=1, wb_reg=5, wb_val=0x00000104. Transfer NOP 0x00000013 → wb_en=0, retire_count increments.
- LB x3 at addr 0x1003; mem_rsp_data=0x80FF1234 after 3 cycles → in_ready=0 while waiting; wb_val=0xFFFFFF80 one cycle after the response. Repeat as LBU → 0x00000080.
- LH x4 at addr 0x2002, data=0x8001ABCD → wb_val=0xFFFF8001. LW at addr 0x2001 → misalign_err pulse, wb_en=0, in_ready stays 1.
- LW x6 with no response for LOAD_TIMEOUT=16 cycles → load_err pulse, no write, retire_count unchanged, in_ready=1 afterward.
- rst asserted 2 cycles into WAIT_LOAD, then a mem_rsp_valid pulse → all outputs 0, no write, state IDLE.
